minimig_reset_request: RTL and testbench

- Initiator side of the system master-reset interface.
- Collects reset requests from four sources:
  - OSD/IO controller
  - keyboard reset combination (Ctrl-Amiga-Amiga)
  - CPU RESET instruction
  - bootloader "bootdone" signature (both CIAs selected in the same cycle)
- Converts a request into a clean, fixed-length `mrst` level for the system reset timer.
- Owns the `boot` flag: set at power-up, cleared by bootdone, never set again.

---
 rtl/minimig_reset_request.sv | 166 ++++++++++++++++
 tb/tb_minimig_reset_request.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/minimig_reset_request.sv
// minimig_reset_request: initiator side of the system master-reset interface.
// Collects OSD, keyboard, CPU RESET and bootloader "bootdone" requests and turns
// the winning one into a fixed-length mrst level for the system reset timer.
// It also owns the boot flag, which is set at power-up and cleared by bootdone.
// Optional feature macro: MINIMIG_RST_CAUSE_EN keeps a register with the cause
// of the last accepted request. Without it, rst_cause is tied to zero.
module minimig_reset_request #(
   parameter int HOLD_TICKS    = 16,
   parameter int KBD_DEBOUNCE  = 8,
   parameter int LOCKOUT_TICKS = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk7_en,
   input  logic       osd_rst,
   input  logic       kbd_rst,
   input  logic       cpu_rst,
   input  logic       cia_sel_a,
   input  logic       cia_sel_b,
   output logic       mrst,
   output logic       boot,
   output logic       busy,
   output logic [2:0] rst_cause
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ASSERT,
      S_RELEASE_WAIT,
      S_LOCKOUT
   } state_t;

   localparam logic [8:0] P_HOLD    = 9'(HOLD_TICKS);
   localparam logic [7:0] P_KBD     = 8'(KBD_DEBOUNCE);
   localparam logic [7:0] P_LOCKOUT = 8'(LOCKOUT_TICKS);

   state_t     r_state;
   state_t     w_stateNext;
   logic [7:0] r_count;
   logic [7:0] w_countNext;
   logic [7:0] r_kbdCount;
   logic [7:0] w_kbdCountNext;
   logic       r_mrst;
   logic       w_mrstNext;
   logic       r_boot;
   logic       w_bootNext;
   logic       w_kbdReq;
   logic       w_bootReq;
   logic       w_holdDone;
   logic [2:0] w_reqCause;

   assign w_kbdReq   = (r_kbdCount == P_KBD);
   assign w_bootReq  = cia_sel_a & cia_sel_b & r_boot;
   // The single RELEASE_WAIT tick is part of the hold, so ASSERT leaves one tick early.
   assign w_holdDone = (({1'b0, r_count} + 9'd2) >= P_HOLD);

   // Keyboard debounce counter: counts while held, saturates, clears on release.
   always_comb begin
      w_kbdCountNext = 8'd0;
      if (kbd_rst) begin
         if (r_kbdCount == P_KBD) begin
            w_kbdCountNext = r_kbdCount;
         end else begin
            w_kbdCountNext = r_kbdCount + 8'd1;
         end
      end
   end

   // Fixed priority encoder for simultaneous requests: OSD, keyboard, CPU, bootdone.
   always_comb begin
      w_reqCause = 3'd0;
      if (osd_rst) begin
         w_reqCause = 3'd1;
      end else if (w_kbdReq) begin
         w_reqCause = 3'd2;
      end else if (cpu_rst) begin
         w_reqCause = 3'd3;
      end else if (w_bootReq) begin
         w_reqCause = 3'd4;
      end
   end

   // Sequence FSM next-state logic: accept, hold, wait for level sources, lock out.
   always_comb begin
      w_stateNext = r_state;
      w_countNext = r_count;
      w_mrstNext  = r_mrst;
      w_bootNext  = r_boot;
      case (r_state)
         S_IDLE: begin
            if (w_reqCause != 3'd0) begin
               w_stateNext = S_ASSERT;
               w_countNext = 8'd0;
               w_mrstNext  = 1'b1;
               if (w_reqCause == 3'd4) begin
                  w_bootNext = 1'b0;
               end
            end
         end
         S_ASSERT: begin
            w_countNext = r_count + 8'd1;
            if (w_holdDone) begin
               w_stateNext = S_RELEASE_WAIT;
            end
         end
         S_RELEASE_WAIT: begin
            if (!osd_rst && !kbd_rst) begin
               w_stateNext = S_LOCKOUT;
               w_mrstNext  = 1'b0;
               w_countNext = 8'd0;
            end
         end
         S_LOCKOUT: begin
            if (r_count == P_LOCKOUT) begin
               w_stateNext = S_IDLE;
            end else begin
               w_countNext = r_count + 8'd1;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
            w_countNext = 8'd0;
            w_mrstNext  = 1'b0;
         end
      endcase
   end

   // State, counters and flags advance only on 7 MHz enable ticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count    <= 8'd0;
         r_kbdCount <= 8'd0;
         r_mrst     <= 1'b0;
         r_boot     <= 1'b1;
      end else if (clk7_en) begin
         r_state    <= w_stateNext;
         r_count    <= w_countNext;
         r_kbdCount <= w_kbdCountNext;
         r_mrst     <= w_mrstNext;
         r_boot     <= w_bootNext;
      end
   end

`ifdef MINIMIG_RST_CAUSE_EN
   logic [2:0] r_cause;

   // Remember the cause of the last accepted request until the next one is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cause <= 3'd0;
      end else if (clk7_en && (r_state == S_IDLE) && (w_reqCause != 3'd0)) begin
         r_cause <= w_reqCause;
      end
   end

   assign rst_cause = r_cause;
`else
   assign rst_cause = 3'd0;
`endif

   assign mrst = r_mrst;
   assign boot = r_boot;
   assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_minimig_reset_request.sv
// tb_minimig_reset_request: directed self-checking bench for minimig_reset_request.
// Expected rst_cause values follow MINIMIG_RST_CAUSE_EN (zero when undefined).
module tb_minimig_reset_request;

   logic       clk;
   logic       reset;
   logic       clk7_en;
   logic       osd_rst;
   logic       kbd_rst;
   logic       cpu_rst;
   logic       cia_sel_a;
   logic       cia_sel_b;
   logic       mrst;
   logic       boot;
   logic       busy;
   logic [2:0] rst_cause;

   int assertCount;
   int failCount;

   minimig_reset_request #(
      .HOLD_TICKS   (16),
      .KBD_DEBOUNCE (8),
      .LOCKOUT_TICKS(32)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clk7_en  (clk7_en),
      .osd_rst  (osd_rst),
      .kbd_rst  (kbd_rst),
      .cpu_rst  (cpu_rst),
      .cia_sel_a(cia_sel_a),
      .cia_sel_b(cia_sel_b),
      .mrst     (mrst),
      .boot     (boot),
      .busy     (busy),
      .rst_cause(rst_cause)
   );

   // Free-running bus clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] expCause(input logic [2:0] c);
`ifdef MINIMIG_RST_CAUSE_EN
      return c;
`else
      return 3'd0;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkCause(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One enabled tick: inputs were set beforehand, outputs are sampled 1ns after the edge.
   task automatic tick();
      clk7_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic runTicks(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
      end
   endtask

   task automatic applyStimulus(input logic osd, input logic kbd, input logic cpu,
                                input logic ca, input logic cb);
      osd_rst   = osd;
      kbd_rst   = kbd;
      cpu_rst   = cpu;
      cia_sel_a = ca;
      cia_sel_b = cb;
   endtask

   // Directed sequence covering every request source and the lockout/boot boundaries.
   initial begin
      assertCount = 0;
      failCount   = 0;
      reset       = 1'b1;
      clk7_en     = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      runTicks(100);
      checkOutput("idle mrst", mrst, 1'b0);
      checkOutput("idle boot", boot, 1'b1);
      checkOutput("idle busy", busy, 1'b0);
      checkCause("idle cause", rst_cause, 3'd0);

      // cpu_rst pulses without clk7_en must be ignored
      clk7_en = 1'b0;
      cpu_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cpu_rst = 1'b0;
      checkOutput("noen mrst", mrst, 1'b0);
      checkOutput("noen busy", busy, 1'b0);

      // CPU reset: request tick N, mrst high for 16 ticks, busy low at N+49
      runTicks(9);
      applyStimulus(0, 0, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("cpu mrst rise", mrst, 1'b1);
      checkOutput("cpu busy", busy, 1'b1);
      checkCause("cpu cause", rst_cause, expCause(3'd3));
      for (int i = 1; i <= 15; i++) begin
         tick();
         checkOutput($sformatf("cpu mrst hold %0d", i), mrst, 1'b1);
      end
      tick();
      checkOutput("cpu mrst fall", mrst, 1'b0);
      checkOutput("cpu busy lockout", busy, 1'b1);
      runTicks(13);
      applyStimulus(0, 0, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("cpu lockout ignore", mrst, 1'b0);
      runTicks(17);
      checkOutput("cpu busy before end", busy, 1'b1);
      tick();
      checkOutput("cpu busy end", busy, 1'b0);
      tick();
      checkOutput("cpu no queued", mrst, 1'b0);
      checkCause("cpu cause held", rst_cause, expCause(3'd3));

      // Keyboard: 7 ticks is too short, 40 ticks holds mrst until release
      applyStimulus(0, 1, 0, 0, 0);
      runTicks(7);
      applyStimulus(0, 0, 0, 0, 0);
      runTicks(2);
      checkOutput("kbd short mrst", mrst, 1'b0);
      checkOutput("kbd short busy", busy, 1'b0);
      applyStimulus(0, 1, 0, 0, 0);
      runTicks(7);
      checkOutput("kbd debounce low", mrst, 1'b0);
      runTicks(2);
      checkOutput("kbd mrst rise", mrst, 1'b1);
      checkCause("kbd cause", rst_cause, expCause(3'd2));
      runTicks(31);
      checkOutput("kbd held mrst", mrst, 1'b1);
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("kbd release mrst", mrst, 1'b0);
      runTicks(34);
      checkOutput("kbd idle busy", busy, 1'b0);

      // Bootdone: dual CIA select clears boot and starts a reset
      applyStimulus(0, 0, 0, 1, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("boot cleared", boot, 1'b0);
      checkOutput("boot mrst rise", mrst, 1'b1);
      checkCause("boot cause", rst_cause, expCause(3'd4));
      runTicks(15);
      checkOutput("boot mrst hold", mrst, 1'b1);
      tick();
      checkOutput("boot mrst fall", mrst, 1'b0);
      runTicks(33);
      checkOutput("boot busy end", busy, 1'b0);
      applyStimulus(0, 0, 0, 1, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      checkOutput("boot repeat mrst", mrst, 1'b0);
      checkOutput("boot repeat busy", busy, 1'b0);
      checkOutput("boot stays clear", boot, 1'b0);

      // OSD and CPU together: OSD wins; then async reset mid-ASSERT
      applyStimulus(1, 0, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkCause("prio cause", rst_cause, expCause(3'd1));
      checkOutput("prio mrst", mrst, 1'b1);
      runTicks(3);
      checkOutput("prio boot", boot, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("areset mrst", mrst, 1'b0);
      checkOutput("areset boot", boot, 1'b1);
      checkOutput("areset busy", busy, 1'b0);
      checkCause("areset cause", rst_cause, 3'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      runTicks(2);
      checkOutput("post reset mrst", mrst, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
